// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed driver for a multi-digit seven-segment display. A hex
//   word, the decimal points and a per-digit blanking mask are latched into
//   shadow registers on a single-cycle load strobe. The driver then scans one
//   digit per refresh slot of CLK_DIV cycles. For the first GUARD cycles of
//   each slot every digit enable is held inactive, so segment data never
//   ghosts onto the neighbouring digit. Leading zeros can be suppressed
//   through a live (unlatched) control input.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   enable    scan enable; 0 blanks the display and restarts the scan
//   load      single-cycle strobe that captures data_in/dp_in/blank_in
//   data_in   hex nibbles; digit 0 = bits [3:0] = rightmost digit
//   dp_in     decimal point per digit, 1 = lit
//   blank_in  per-digit forced blank, 1 = blank
//   lz_blank  1 = suppress leading zeros (digit 0 is never suppressed)
//   seg_out   segments {g,f,e,d,c,b,a}, with polarity set by SEG_ACTIVE_LOW
//   dp_out    decimal point segment, with polarity set by SEG_ACTIVE_LOW
//   dig_sel   one-hot digit enable, with polarity set by DIG_ACTIVE_LOW
//   scan_idx  index of the digit currently being driven
// -----------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      lz_blank,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic                  SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic                  DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_INV ? '1 : '0;

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;

  // Scan timing
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;

  // Registered outputs
  logic [6:0]              r_seg;
  logic                    r_dp_o;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic [IW-1:0]           r_scan;

  // Combinational view of the digit selected by r_idx
  logic [3:0]              w_nib;
  logic                    w_dp_cur;
  logic                    w_blank_cur;
  logic [NUM_DIGITS-1:0]   w_lead;
  logic                    w_run;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_on;
  logic [6:0]              w_seg_drv;
  logic                    w_dp_drv;
  logic [NUM_DIGITS-1:0]   w_dig_drv;

  // Active-high segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  always_comb begin
    // w_lead[k] is set when nibbles k..NUM_DIGITS-1 are all zero, built as a
    // running AND from the most significant digit downwards.
    w_lead = '0;
    w_run  = 1'b1;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      w_run       = w_run & (r_data[4*(k-1) +: 4] == 4'h0);
      w_lead[k-1] = w_run;
    end

    w_nib       = '0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b0;
    w_onehot    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_onehot[k] = (r_idx == IW'(k));
      if (r_idx == IW'(k)) begin
        w_nib       = r_data[4*k +: 4];
        w_dp_cur    = r_dp[k];
        w_blank_cur = r_blank[k] | (lz_blank & w_lead[k] & (k != 0));
      end
    end

    w_seg_on  = w_blank_cur ? 7'h00 : seg_decode(w_nib);
    w_seg_drv = SEG_INV ? ~w_seg_on : w_seg_on;
    w_dp_drv  = SEG_INV ? ~w_dp_cur : w_dp_cur;
    w_dig_drv = DIG_INV ? ~w_onehot : w_onehot;
  end

  // Shadow capture is independent of scan timing; the driven digit picks up
  // new contents on the edge after capture, even mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_dp    <= '0;
      r_blank <= '0;
    end else if (load) begin
      r_data  <= data_in;
      r_dp    <= dp_in;
      r_blank <= blank_in;
    end
  end

  // Outputs are derived from the pre-edge slot counter and index, so the
  // guard window and the digit enable line up on the same output edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_scan <= '0;
      r_seg  <= SEG_OFF;
      r_dp_o <= DP_OFF;
      r_dig  <= DIG_OFF;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_scan <= '0;
      r_seg  <= SEG_OFF;
      r_dp_o <= DP_OFF;
      r_dig  <= DIG_OFF;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_scan <= r_idx;
      if (r_cnt < GUARD_C) begin
        r_seg  <= SEG_OFF;
        r_dp_o <= DP_OFF;
        r_dig  <= DIG_OFF;
      end else begin
        r_seg  <= w_seg_drv;
        r_dp_o <= w_dp_drv;
        r_dig  <= w_dig_drv;
      end
    end
  end

  assign seg_out  = r_seg;
  assign dp_out   = r_dp_o;
  assign dig_sel  = r_dig;
  assign scan_idx = r_scan;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised, time-multiplexed driver for a multi-digit common-anode/cathode seven-segment display.
- Latches an N-digit hex word, decimal points and a blanking mask into a shadow register.
- Scans one digit per refresh slot, with an anti-ghosting guard interval and optional leading-zero suppression.
- Sits between the ADC/EEPROM datapath and the board display pins, replacing per-digit static decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 50000, clock cycles per digit slot (>= GUARD+2)
GUARD, 16, cycles at start of each slot with all digit enables inactive
SEG_ACTIVE_LOW, 1, 1: segment/dp lit when 0; 0: lit when 1
DIG_ACTIVE_LOW, 1, 1: digit enable asserted when 0; 0: asserted when 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; 0 blanks the display
load  in  1  single-cycle strobe; captures data_in/dp_in/blank_in
data_in  in  4*NUM_DIGITS  hex nibbles, digit 0 = bits [3:0] = rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  in  NUM_DIGITS  per-digit force-blank, 1 = blank
lz_blank  in  1  1 = suppress leading zeros (live, not latched)
seg_out  out  7  segments {g,f,e,d,c,b,a} = bits [6:0]
dp_out  out  1  decimal point segment
dig_sel  out  NUM_DIGITS  one-hot digit enable
scan_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently driven

Behaviour:
- Reset (rst_n=0, async): shadow regs cleared; slot counter=0; scan_idx=0; all outputs inactive. seg_out=7'h7F and dp_out=1 when SEG_ACTIVE_LOW, else 0. dig_sel all 1s when DIG_ACTIVE_LOW, else 0.
- Shadow: on load=1 at edge t, shadow takes inputs at t+1. The digit being driven switches to new data one cycle after capture, even mid-slot. No effect on scan timing.
- Slot counter: counts 0..CLK_DIV-1 while enable=1. At CLK_DIV-1 it wraps to 0 and scan_idx advances: 0,1,..,NUM_DIGITS-1,0.
- Guard: while counter < GUARD, dig_sel is all inactive and seg/dp are off. From counter=GUARD to CLK_DIV-1, dig_sel asserts only bit scan_idx.
- Decode (active-high form; inverted when SEG_ACTIVE_LOW):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F
  - A:77, b:7C, C:39, d:5E, E:79, F:71
- Blanking: digit k is blank if blank_in[k] is latched, or if lz_blank=1 and all of nibbles k..NUM_DIGITS-1 are 0 with k != 0. Digit 0 is never zero-suppressed.
- A blank digit has all segments off. dp follows shadow dp independently of blanking.
- Outputs are registered: seg_out/dp_out/dig_sel/scan_idx reflect state from the previous edge. Segment data and digit enable change on the same edge.
- enable=0: next edge forces counter=0, scan_idx=0 and all outputs inactive; shadow is retained. On re-enable, scanning restarts at digit 0 with a full guard interval.
- load and slot wrap on the same edge: both take effect; there is no priority conflict.
- NUM_DIGITS=1: scan_idx stays 0; the guard still applies each slot.

Test Plan:
- Reset mid-scan (NUM_DIGITS=4, CLK_DIV=8, GUARD=2, active-low): assert rst_n=0 at cycle 13 -> immediately seg_out=7'h7F, dp_out=1, dig_sel=4'hF, scan_idx=0.
- load data_in=16'h12AF, dp_in=4'b0100, enable=1 -> each slot: 2 cycles dig_sel=F, then 6 cycles at the scan_idx digit:
  - digit 0: dig_sel=E, seg=~71=0E
  - digit 1: dig_sel=D, seg=~77=08
  - digit 2: dig_sel=B, seg=~5B=24, dp_out=0
  - digit 3: dig_sel=7, seg=~06=79
- Leading-zero: data_in=16'h0050, lz_blank=1 -> digits 3,2 seg=7F; digit 1 seg=12; digit 0 seg=40. With data_in=16'h0000, digit 0 shows 40 and the rest are blank.
- blank_in=4'b0010 with data_in=16'h8888 -> digit 1 seg=7F; the others seg=00.
- load=1 at counter=5 of digit 2 with new nibble 3 -> seg_out changes to 30 two edges later, with dig_sel unchanged. The slot still ends at counter=7.
- enable dropped at counter=4 of digit 3 then raised -> all outputs inactive the next cycle. Restart shows dig_sel=F for 2 cycles, then digit 0.
